// File: rtl/serial_parity_rx_pkg.sv
// Shared types and constants for the serial parity receiver.
// No logic: the FSM state encoding, parity-sense constants and counter width live here.
// Imported by the receiver top, its accumulator and the bench.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam bit PAR_EVEN  = 1'b0;
  localparam bit PAR_ODD   = 1'b1;
  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/serial_parity_rx_if.sv
// Serial-in / word-out handshake bundle of the parity receiver.
// Latency: none (wires only).
// Backpressure: sin_ready from the receiver, out_ready from the word consumer.
interface serial_parity_rx_if #(
  parameter int DATA_W = 8
);

  logic              sin_valid;
  logic              sin_bit;
  logic              sin_sof;
  logic              sin_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  // Link/consumer side: drives serial bits and the word-level ready.
  modport master (
    output sin_valid, sin_bit, sin_sof, out_ready,
    input  sin_ready, out_data, out_err, out_valid
  );

  // Receiver side.
  modport slave (
    input  sin_valid, sin_bit, sin_sof, out_ready,
    output sin_ready, out_data, out_err, out_valid
  );

endinterface

// File: rtl/serial_parity_rx_accum.sv
// Running XOR of the bits of one frame (data bits only).
// Latency: result visible the cycle after load/en.
// Backpressure: none; the caller only pulses load/en on accepted bits.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic en,
  input  logic din,
  output logic acc
);

  // clear wins over load (frame start), which wins over accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 1'b0;
    end else if (clear) begin
      acc <= 1'b0;
    end else if (load) begin
      acc <= din;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial LSB-first frame receiver: DATA_W data bits + parity -> word + error flag.
// Latency: out_valid rises on the edge that accepts the parity bit.
// Backpressure: word held and sin_ready low until out_ready; optional PARITY_ERR_CNT_EN error counter.
module serial_parity_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_parity_rx_if.slave    bus,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              acc;
  logic              accept;
  logic              frame_start;
  logic              last_data;
  logic              shift_en;
  logic              capture;
  logic              release_w;
  logic              par_err;

  // HOLD is the only state that refuses serial bits
  assign bus.sin_ready = (state_q != HOLD);
  assign accept        = bus.sin_valid && bus.sin_ready;
  // an accepted sof always (re)starts a frame, discarding any partial one
  assign frame_start   = accept && bus.sin_sof;
  assign last_data     = (cnt_q == CNT_W'(DATA_W - 1));
  assign par_err       = acc ^ bus.sin_bit ^ ODD_PARITY;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and per-cycle datapath controls
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    capture   = 1'b0;
    release_w = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) state_d = SHIFT;
      end
      SHIFT: begin
        if (frame_start) begin
          state_d = SHIFT;
        end else if (accept) begin
          shift_en = 1'b1;
          if (last_data) state_d = PAR;
        end
      end
      PAR: begin
        if (frame_start) begin
          state_d = SHIFT;
        end else if (accept) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_valid && bus.out_ready) begin
          release_w = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  parity_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (release_w),
    .load  (frame_start),
    .en    (shift_en),
    .din   (bus.sin_bit),
    .acc   (acc)
  );

  // deserialiser: bit0 on frame start, then bit at position cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (frame_start) begin
      shreg_q <= {{(DATA_W-1){1'b0}}, bus.sin_bit};
      cnt_q   <= CNT_W'(1);
    end else if (shift_en) begin
      shreg_q[cnt_q] <= bus.sin_bit;
      cnt_q          <= cnt_q + CNT_W'(1);
    end else if (capture) begin
      cnt_q <= '0;
    end
  end

  // output word register: loaded with the parity bit, frozen through HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_err   <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (capture) begin
      bus.out_data  <= shreg_q;
      bus.out_err   <= par_err;
      bus.out_valid <= 1'b1;
    end else if (release_w) begin
      bus.out_valid <= 1'b0;
    end
  end

  // busy tracks the registered state so it changes with the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // saturating count of bad words, bumped as the word enters HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (capture && par_err && (err_count != {ERR_CNT_W{1'b1}})) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an even-parity and an odd-parity instance share stimulus.
// Latency checked: word visible 1 ns after the parity-bit edge, gone one edge later.
// Backpressure, abort, reset and (with PARITY_ERR_CNT_EN) counter saturation exercised.
module tb_serial_parity_rx;
  import parity_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       e0;
    logic       e1;
  } vec_t;

`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sin_valid;
  logic       sin_bit;
  logic       sin_sof;
  logic       out_ready;
  logic       busy0;
  logic       busy1;
  logic [7:0] err_count0;
  logic [7:0] err_count1;

  int checks;
  int failures;
  int exp_cnt0;
  int exp_cnt1;

  serial_parity_rx_if #(.DATA_W(8)) b0 ();
  serial_parity_rx_if #(.DATA_W(8)) b1 ();

  assign b0.sin_valid = sin_valid;
  assign b0.sin_bit   = sin_bit;
  assign b0.sin_sof   = sin_sof;
  assign b0.out_ready = out_ready;
  assign b1.sin_valid = sin_valid;
  assign b1.sin_bit   = sin_bit;
  assign b1.sin_sof   = sin_sof;
  assign b1.out_ready = out_ready;

  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(PAR_EVEN)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b0),
    .busy      (busy0),
    .err_count (err_count0)
  );

  serial_parity_rx #(.DATA_W(8), .ODD_PARITY(PAR_ODD)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b1),
    .busy      (busy1),
    .err_count (err_count1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cnt_exp(input int c);
    return CNT_EN ? 8'(c) : 8'h00;
  endfunction

  task automatic note_err(input logic e0, input logic e1);
    if (e0 && exp_cnt0 < 255) exp_cnt0++;
    if (e1 && exp_cnt1 < 255) exp_cnt1++;
  endtask

  task automatic chk_cnt(input string tag);
    chk8({tag, " err_count0"}, err_count0, cnt_exp(exp_cnt0));
    chk8({tag, " err_count1"}, err_count1, cnt_exp(exp_cnt1));
  endtask

  task automatic send_bit(input logic b, input logic sof);
    sin_valid = 1'b1;
    sin_bit   = b;
    sin_sof   = sof;
    @(posedge clk);
    #1;
    sin_valid = 1'b0;
    sin_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == 0));
    send_bit(p, 1'b0);
  endtask

  // checks both instances right after the parity edge
  task automatic chk_word(input string tag, input logic [7:0] d, input logic e0, input logic e1);
    chk1({tag, " out_valid0"}, b0.out_valid, 1'b1);
    chk1({tag, " out_valid1"}, b1.out_valid, 1'b1);
    chk8({tag, " out_data0"}, b0.out_data, d);
    chk8({tag, " out_data1"}, b1.out_data, d);
    chk1({tag, " out_err0"}, b0.out_err, e0);
    chk1({tag, " out_err1"}, b1.out_err, e1);
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, " out_valid0 low"}, b0.out_valid, 1'b0);
    chk1({tag, " out_valid1 low"}, b1.out_valid, 1'b0);
    chk1({tag, " busy0 low"}, busy0, 1'b0);
  endtask

  vec_t tbl [9];

  initial begin
    checks    = 0;
    failures  = 0;
    exp_cnt0  = 0;
    exp_cnt1  = 0;
    rst_n     = 1'b0;
    sin_valid = 1'b0;
    sin_bit   = 1'b0;
    sin_sof   = 1'b0;
    out_ready = 1'b1;

    //               data   par   err(even) err(odd)
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h07, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{8'h01, 1'b1, 1'b0, 1'b1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst out_valid0", b0.out_valid, 1'b0);
    chk8("rst out_data0", b0.out_data, 8'h00);
    chk1("rst out_err0", b0.out_err, 1'b0);
    chk1("rst busy0", busy0, 1'b0);
    chk_cnt("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk1("rst sin_ready0", b0.sin_ready, 1'b1);
    chk1("rst sin_ready1", b1.sin_ready, 1'b1);

    // table-driven frames, consumer always ready
    for (int v = 0; v < 9; v++) begin
      send_frame(tbl[v].d, tbl[v].p);
      chk_word($sformatf("vec%0d", v), tbl[v].d, tbl[v].e0, tbl[v].e1);
      note_err(tbl[v].e0, tbl[v].e1);
      chk_cnt($sformatf("vec%0d", v));
      @(posedge clk);
      #1;
      chk_idle($sformatf("vec%0d", v));
    end

    // backpressure: word held, serial bits refused while out_ready low
    out_ready = 1'b0;
    send_frame(8'h5A, 1'b0);
    chk_word("bp", 8'h5A, 1'b0, 1'b1);
    note_err(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      sin_valid = 1'b1;
      sin_sof   = 1'b1;
      sin_bit   = k[0];
      @(posedge clk);
      #1;
      chk1("bp hold out_valid0", b0.out_valid, 1'b1);
      chk8("bp hold out_data0", b0.out_data, 8'h5A);
      chk1("bp hold out_err1", b1.out_err, 1'b1);
      chk1("bp hold sin_ready0", b0.sin_ready, 1'b0);
      chk1("bp hold busy0", busy0, 1'b1);
    end
    sin_valid = 1'b0;
    sin_sof   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_idle("bp release");
    chk1("bp release sin_ready0", b0.sin_ready, 1'b1);
    chk_cnt("bp");

    // abort in SHIFT: three bits, then a fresh sof frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk1("abort shift busy0", busy0, 1'b1);
    chk1("abort shift no out_valid0", b0.out_valid, 1'b0);
    send_frame(8'h3C, 1'b0);
    chk_word("abort shift", 8'h3C, 1'b0, 1'b1);
    note_err(1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk_idle("abort shift");

    // abort in PAR: the bit in the parity slot carries sof
    for (int i = 0; i < 8; i++) send_bit(1'b1, (i == 0));
    chk1("abort par busy0", busy0, 1'b1);
    chk1("abort par no out_valid0", b0.out_valid, 1'b0);
    send_frame(8'h96, 1'b0);
    chk_word("abort par", 8'h96, 1'b0, 1'b1);
    note_err(1'b0, 1'b1);
    chk_cnt("abort");
    @(posedge clk);
    #1;
    chk_idle("abort par");

    // bits without sof in IDLE are dropped
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0);
    chk_idle("idle drop");

    // mid-frame asynchronous reset
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    chk1("pre-rst busy0", busy0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk8("async rst out_data0", b0.out_data, 8'h00);
    chk1("async rst out_err1", b1.out_err, 1'b0);
    chk1("async rst busy0", busy0, 1'b0);
    chk1("async rst out_valid0", b0.out_valid, 1'b0);
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    chk_cnt("async rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8'hFF, 1'b0);
    chk_word("post rst", 8'hFF, 1'b0, 1'b1);
    note_err(1'b0, 1'b1);
    chk_cnt("post rst");
    @(posedge clk);
    #1;
    chk_idle("post rst");

`ifdef PARITY_ERR_CNT_EN
    // 260 bad words for the even instance: counter must stick at FF
    for (int f = 0; f < 260; f++) begin
      send_frame(8'h01, 1'b0);
      note_err(1'b1, 1'b0);
      if (f == 254) chk_cnt("sat 255th");
      @(posedge clk);
      #1;
    end
    chk_cnt("sat final");
    chk8("sat err_count0 FF", err_count0, 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
